// File: rtl/cpu_ctx_regs.sv
// Architectural register file (PC, IR, ACC, MDR, MAR, Z) with a LIFO context
// stack that saves and restores {PC, ACC, Z} for interrupt/call handling.
module cpu_ctx_regs #(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 8,
   parameter int                CTX_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             stall,
   input  logic                             ld_pc,
   input  logic                             ld_ir,
   input  logic                             ld_acc,
   input  logic                             ld_mdr,
   input  logic                             ld_mar,
   input  logic                             ld_z,
   input  logic [ADDR_W-1:0]                pc_next,
   input  logic [DATA_W-1:0]                ir_next,
   input  logic [DATA_W-1:0]                acc_next,
   input  logic [DATA_W-1:0]                mdr_next,
   input  logic [ADDR_W-1:0]                mar_next,
   input  logic                             zflag_next,
   input  logic                             pc_inc,
   input  logic                             ctx_save,
   input  logic                             ctx_restore,
   input  logic                             err_clr,
   output logic [ADDR_W-1:0]                pc_reg,
   output logic [DATA_W-1:0]                ir_reg,
   output logic [DATA_W-1:0]                acc_reg,
   output logic [DATA_W-1:0]                mdr_reg,
   output logic [ADDR_W-1:0]                mar_reg,
   output logic                             zflag_reg,
   output logic [$clog2(CTX_DEPTH+1)-1:0]   ctx_count,
   output logic                             ctx_full,
   output logic                             ctx_empty,
   output logic                             ctx_err
);

   localparam int CNT_W = $clog2(CTX_DEPTH+1);
   localparam int ENT_W = ADDR_W + DATA_W + 1;

   logic [CTX_DEPTH-1:0][ENT_W-1:0] stack_flat;
   logic [ENT_W-1:0]                top_entry;
   logic [CNT_W-1:0]                top_idx;
   logic [CNT_W-1:0]                count_next;
   logic                            save_ok;
   logic                            restore_ok;
   logic                            err_event;
   logic                            load_en;

   assign load_en    = ~stall;
   assign save_ok    = ctx_save & ~ctx_restore & ~ctx_full;
   assign restore_ok = ctx_restore & ~ctx_save & ~ctx_empty;
   // Conflict, overflow and underflow all funnel into the one sticky flag.
   assign err_event  = (ctx_save & ctx_restore)
                     | (ctx_save & ~ctx_restore & ctx_full)
                     | (ctx_restore & ~ctx_save & ctx_empty);
   assign top_idx    = ctx_count - CNT_W'(1);

   // Entry gi is written only when it is the next free slot.
   generate
      for (genvar gi = 0; gi < CTX_DEPTH; gi++) begin : g_stack
         logic [ENT_W-1:0] entry_reg;
         always_ff @(posedge clk) begin
            if (save_ok && (ctx_count == CNT_W'(gi)))
               entry_reg <= {pc_reg, acc_reg, zflag_reg};
         end
         assign stack_flat[gi] = entry_reg;
      end
   endgenerate

   always_comb begin
      top_entry = '0;
      for (int i = 0; i < CTX_DEPTH; i++) begin
         if (top_idx == CNT_W'(i))
            top_entry = stack_flat[i];
      end
   end

   always_comb begin
      count_next = ctx_count;
      if (save_ok)
         count_next = ctx_count + CNT_W'(1);
      else if (restore_ok)
         count_next = ctx_count - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg    <= RESET_PC;
         ir_reg    <= '0;
         acc_reg   <= '0;
         mdr_reg   <= '0;
         mar_reg   <= '0;
         zflag_reg <= 1'b0;
         ctx_count <= '0;
         ctx_full  <= 1'b0;
         ctx_empty <= 1'b1;
         ctx_err   <= 1'b0;
      end else begin
         // A restore owns PC/ACC/Z for this cycle; their normal loads are dropped.
         if (restore_ok) begin
            {pc_reg, acc_reg, zflag_reg} <= top_entry;
         end else if (load_en) begin
            if (ld_pc)
               pc_reg <= pc_next;
            else if (pc_inc)
               pc_reg <= pc_reg + ADDR_W'(1);
            if (ld_acc)
               acc_reg <= acc_next;
            if (ld_z)
               zflag_reg <= zflag_next;
         end
         if (load_en) begin
            if (ld_ir)
               ir_reg <= ir_next;
            if (ld_mdr)
               mdr_reg <= mdr_next;
            if (ld_mar)
               mar_reg <= mar_next;
         end
         ctx_count <= count_next;
         ctx_full  <= (count_next == CNT_W'(CTX_DEPTH));
         ctx_empty <= (count_next == '0);
         if (err_event)
            ctx_err <= 1'b1;
         else if (err_clr)
            ctx_err <= 1'b0;
      end
   end

endmodule
